pc_sequencer: RTL
=================

# pc_sequencer

Fetch-side controller for the program counter of the single-cycle core. It owns the PC value, issues one instruction-memory request at a time, and holds each fetched instruction until the execute stage retires it. At retirement it picks the next PC: sequential, branch/jump redirect, trap entry, trap return (`mret`), or halt. It replaces the free-running `pc + 4` path in front of the PC register.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on trap entry (word-aligned)

- `clk` in 1, clock, rising edge
- `rst` in 1, reset, asynchronous, active-high
- `imem_req_o` out 1, fetch request
- `imem_addr_o` out 32, fetch address; equals `pc_o`
- `imem_gnt_i` in 1, memory accepted the request this cycle
- `imem_rvalid_i` in 1, read data valid
- `imem_rdata_i` in 32, instruction word
- `instr_valid_o` out 1, `instr_o` / `instr_pc_o` hold a valid instruction
- `instr_o` out 32, fetched instruction
- `instr_pc_o` out 32, address of `instr_o`
- `instr_ready_i` in 1, execute retires the presented instruction
- `redirect_i` in 1, retiring instruction is a taken branch or jump
- `redirect_target_i` in 32, target of the redirect
- `trap_i` in 1, retiring instruction raises an exception
- `mret_i` in 1, retiring instruction is a trap return
- `halt_i` in 1, retiring instruction halts the core
- `pc_o` out 32, current fetch PC
- `epc_o` out 32, saved exception PC
- `misalign_o` out 1, one-cycle pulse when a misaligned redirect is converted to a trap
- `halted_o` out 1, core is halted

## Operation
- States: REQ, WAIT, HOLD, HALT. Reset state is REQ.
- **REQ**
  - `imem_req_o`=1 with `imem_addr_o`=`pc_o`, both held stable until `imem_gnt_i`.
  - On `imem_gnt_i` -> WAIT.
  - `imem_rvalid_i` is ignored in REQ.
- **WAIT**
  - `imem_req_o`=0.
  - On `imem_rvalid_i`: register `instr_o`=`imem_rdata_i` and `instr_pc_o`=`pc_o`, set `instr_valid_o`, -> HOLD.
- **HOLD**
  - `instr_valid_o`=1; `instr_o` and `instr_pc_o` are stable.
  - Retire = `instr_valid_o` & `instr_ready_i`.
  - `redirect_i`, `trap_i`, `mret_i` and `halt_i` are sampled only in the retire cycle and ignored at all other times.
  - On retire: clear `instr_valid_o`, load the next PC, -> REQ (or HALT).
- **Next-PC priority** (highest first):
  1. `trap_i`: `epc_o`<=`instr_pc_o`, PC<=`TRAP_VECTOR`.
  2. `halt_i`: -> HALT; PC<=`instr_pc_o`+4.
  3. `mret_i`: PC<=`epc_o`.
  4. `redirect_i` with `redirect_target_i[1:0]`!=0: treated as a trap. `epc_o`<=`instr_pc_o`, PC<=`TRAP_VECTOR`, `misalign_o` pulses.
  5. `redirect_i` with an aligned target: PC<=`redirect_target_i`.
  6. Otherwise: PC<=`instr_pc_o`+4.
- **Arithmetic:** 32-bit addition, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No exception on wrap.
- **HALT:** no requests; `halted_o`=1; `instr_valid_o`=0. Left only by `rst`.
- **Reset values:**
  - `pc_o`=`imem_addr_o`=`RESET_PC`, `epc_o`=0.
  - `instr_o`=0, `instr_pc_o`=0.
  - `instr_valid_o`=0, `misalign_o`=0, `halted_o`=0.
  - `imem_req_o`=1 from the first cycle after `rst` deasserts; held at 0 while `rst` is asserted.

## Timing
- At most one outstanding fetch.
- `imem_gnt_i` may arrive in the first REQ cycle.
- `imem_rvalid_i` arrives no earlier than the cycle after the grant.
- Best case is 3 cycles per instruction:
  - cycle 0: REQ+gnt
  - cycle 1: rvalid
  - cycle 2: HOLD with `instr_ready_i`
  - next REQ in cycle 3 with the new PC
- `instr_valid_o` rises the cycle after `imem_rvalid_i`.
- `pc_o` updates the cycle after retire.
- `misalign_o` and the `epc_o` update are visible the cycle after retire.
- **Reset mid-operation:** all outputs take reset values asynchronously. Any late `imem_rvalid_i` arriving after reset lands in REQ and is dropped.
- **Simultaneous `trap_i` and `redirect_i`:** trap wins; the redirect is lost.
- **Simultaneous `mret_i` and `trap_i`:** trap wins; `epc_o` is overwritten.

## Test plan
- Reset release, `gnt` immediate, `rvalid` 1 cycle later, `ready`=1 each HOLD -> fetch addresses 0x0, 0x4, 0x8, one every 3 cycles; `instr_pc_o` matches each address.
- Hold `imem_gnt_i` low for 4 cycles -> `imem_req_o`/`imem_addr_o` stable at 0x4 for all 4 cycles. Hold `instr_ready_i` low 3 cycles -> `instr_o` stable, no new request.
- Retire at 0x10 with `redirect_i`, target 0x40 -> next `imem_addr_o`=0x40. Repeat with target 0x42 -> `misalign_o` pulse, `epc_o`=0x10, next address 0x100.
- `trap_i` at 0x20 -> address 0x100, `epc_o`=0x20. Later `mret_i` retire -> address 0x20. Same cycle `trap_i`+`redirect_i`(0x80) -> address 0x100.
- `halt_i` at 0x8 -> `halted_o`=1, no `imem_req_o` for 20 cycles. PC at 0xFFFF_FFFC sequential -> next address 0x0.
- Assert `rst` while in WAIT, then deliver `imem_rvalid_i` after release -> response ignored, `instr_valid_o` stays 0, request reissued at `RESET_PC`.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus bundle for pc_sequencer: instruction memory port, execute
// handshake with retirement qualifiers, and status outputs.
interface pc_sequencer_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        trap_i;
  logic        mret_i;
  logic        halt_i;
  logic [31:0] pc_o;
  logic [31:0] epc_o;
  logic        misalign_o;
  logic        halted_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i, redirect_i, redirect_target_i, trap_i, mret_i, halt_i,
    output pc_o, epc_o, misalign_o, halted_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i, redirect_i, redirect_target_i, trap_i, mret_i, halt_i,
    input  pc_o, epc_o, misalign_o, halted_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: one outstanding instruction fetch, holds the
// fetched word until retirement, then selects the next PC.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] epc, epc_d;
  logic [31:0] instr, instr_d;
  logic [31:0] instr_pc, instr_pc_d;
  logic        misalign, misalign_d;
  logic [31:0] pc_seq;

  assign pc_seq = instr_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    epc_d      = epc;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    misalign_d = 1'b0;
    unique case (state)
      S_REQ: if (bus.imem_gnt_i) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid_i) begin
          instr_d    = bus.imem_rdata_i;
          instr_pc_d = pc;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // qualifiers only matter in the retire cycle; priority order matters
        if (bus.instr_ready_i) begin
          state_d = S_REQ;
          if (bus.trap_i) begin
            epc_d = instr_pc;
            pc_d  = TRAP_VECTOR;
          end else if (bus.halt_i) begin
            state_d = S_HALT;
            pc_d    = pc_seq;
          end else if (bus.mret_i) begin
            pc_d = epc;
          end else if (bus.redirect_i && (bus.redirect_target_i[1:0] != 2'b00)) begin
            epc_d      = instr_pc;
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
          end else if (bus.redirect_i) begin
            pc_d = bus.redirect_target_i;
          end else begin
            pc_d = pc_seq;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      epc      <= '0;
      instr    <= '0;
      instr_pc <= '0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_d;
      epc      <= epc_d;
      instr    <= instr_d;
      instr_pc <= instr_pc_d;
      misalign <= misalign_d;
    end
  end

  // Request is masked by rst so nothing is issued while reset is held.
  assign bus.imem_req_o    = (state == S_REQ) && !rst;
  assign bus.imem_addr_o   = pc;
  assign bus.pc_o          = pc;
  assign bus.epc_o         = epc;
  assign bus.instr_o       = instr;
  assign bus.instr_pc_o    = instr_pc;
  assign bus.instr_valid_o = (state == S_HOLD);
  assign bus.misalign_o    = misalign;
  assign bus.halted_o      = (state == S_HALT);

endmodule
